// File: rtl/div_pkg.sv
// Shared RV32M divide definitions: func3 codes, divider state encoding and operand helpers.
package div_pkg;

  localparam int unsigned XLEN_P = 32;

  localparam logic [6:0] INST_TYPE_R_M = 7'b0110011;

  localparam logic [2:0] INST_MUL    = 3'b000;
  localparam logic [2:0] INST_MULH   = 3'b001;
  localparam logic [2:0] INST_MULHSU = 3'b010;
  localparam logic [2:0] INST_MULHU  = 3'b011;
  localparam logic [2:0] INST_DIV    = 3'b100;
  localparam logic [2:0] INST_DIVU   = 3'b101;
  localparam logic [2:0] INST_REM    = 3'b110;
  localparam logic [2:0] INST_REMU   = 3'b111;

  typedef enum logic [1:0] {
    DIV_IDLE  = 2'd0,
    DIV_START = 2'd1,
    DIV_CALC  = 2'd2,
    DIV_END   = 2'd3
  } div_state_e;

  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == INST_DIV) || (op == INST_REM);
  endfunction

  function automatic logic is_rem_op(input logic [2:0] op);
    return (op == INST_REM) || (op == INST_REMU);
  endfunction

  function automatic logic [XLEN_P-1:0] neg32(input logic [XLEN_P-1:0] v);
    return (~v) + {{(XLEN_P-1){1'b0}}, 1'b1};
  endfunction

  // Magnitude for signed ops, pass-through for unsigned; 0x80000000 maps to itself.
  function automatic logic [XLEN_P-1:0] mag32(input logic [XLEN_P-1:0] v, input logic sgn);
    return (sgn && v[XLEN_P-1]) ? neg32(v) : v;
  endfunction

endpackage

// File: rtl/div.sv
// Multi-cycle RV32M divider (DIV/DIVU/REM/REMU), radix-2 restoring, one quotient bit per cycle.
// Optional DIV_FAST_SPECIAL_EN: divide-by-zero and signed overflow resolved in START (2-cycle latency).
module div
  import div_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            ready_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_addr_o
);

  div_state_e      state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic [XLEN-1:0] dividend_q, dividend_d;
  logic [XLEN-1:0] divisor_q, divisor_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quot_q, quot_d;
  logic [XLEN-1:0] bmag_q, bmag_d;
  logic [4:0]      count_q, count_d;
  logic            busy_q, busy_d;
  logic            ready_q, ready_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [4:0]      rd_out_q, rd_out_d;

  logic            op_signed;
  logic            op_rem;
  logic            a_neg;
  logic            b_neg;
  logic            b_zero;
  logic [XLEN:0]   rem_shift;
  logic [XLEN:0]   trial;
  logic [XLEN-1:0] step_rem;
  logic [XLEN-1:0] step_quot;
  logic [XLEN-1:0] fix_quot;
  logic [XLEN-1:0] fix_rem;
  logic [XLEN-1:0] final_res;

  always_comb begin
    op_signed = is_signed_op(op_q);
    op_rem    = is_rem_op(op_q);
    a_neg     = op_signed && dividend_q[XLEN-1];
    b_neg     = op_signed && divisor_q[XLEN-1];
    b_zero    = (divisor_q == '0);
  end

  // One restoring step: the remainder is bounded by |b|, so bit XLEN of the trial is its sign.
  always_comb begin
    rem_shift = {rem_q, quot_q[XLEN-1]};
    trial     = rem_shift - {1'b0, bmag_q};
    if (!trial[XLEN]) begin
      step_rem  = trial[XLEN-1:0];
      step_quot = {quot_q[XLEN-2:0], 1'b1};
    end else begin
      step_rem  = rem_shift[XLEN-1:0];
      step_quot = {quot_q[XLEN-2:0], 1'b0};
    end
  end

  // Quotient negation is suppressed for b = 0 so the all-ones result survives signed ops.
  always_comb begin
    fix_quot  = ((a_neg ^ b_neg) && !b_zero) ? neg32(step_quot) : step_quot;
    fix_rem   = a_neg ? neg32(step_rem) : step_rem;
    final_res = op_rem ? fix_rem : fix_quot;
  end

`ifdef DIV_FAST_SPECIAL_EN
  logic            sgn_ovf;
  logic [XLEN-1:0] special_res;

  always_comb begin
    sgn_ovf = op_signed && (dividend_q == {1'b1, {(XLEN-1){1'b0}}}) && (divisor_q == '1);
    if (b_zero) begin
      special_res = op_rem ? dividend_q : '1;
    end else begin
      special_res = op_rem ? '0 : dividend_q;
    end
  end
`endif

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    rd_d       = rd_q;
    rem_d      = rem_q;
    quot_d     = quot_q;
    bmag_d     = bmag_q;
    count_d    = count_q;
    busy_d     = 1'b0;
    ready_d    = 1'b0;
    result_d   = '0;
    rd_out_d   = '0;

    unique case (state_q)
      DIV_IDLE: begin
        if (start_i) begin
          state_d    = DIV_START;
          op_d       = op_i;
          dividend_d = dividend_i;
          divisor_d  = divisor_i;
          rd_d       = rd_addr_i;
          busy_d     = 1'b1;
        end
      end
      DIV_START: begin
        rem_d   = '0;
        quot_d  = mag32(dividend_q, op_signed);
        bmag_d  = mag32(divisor_q, op_signed);
        count_d = '0;
        state_d = DIV_CALC;
        busy_d  = 1'b1;
`ifdef DIV_FAST_SPECIAL_EN
        if (b_zero || sgn_ovf) begin
          state_d  = DIV_END;
          busy_d   = 1'b0;
          ready_d  = 1'b1;
          result_d = special_res;
          rd_out_d = rd_q;
        end
`endif
      end
      DIV_CALC: begin
        rem_d   = step_rem;
        quot_d  = step_quot;
        count_d = count_q + 5'd1;
        if (count_q == 5'd31) begin
          state_d  = DIV_END;
          ready_d  = 1'b1;
          result_d = final_res;
          rd_out_d = rd_q;
        end else begin
          busy_d = 1'b1;
        end
      end
      DIV_END: begin
        state_d = DIV_IDLE;
      end
      default: begin
        state_d = DIV_IDLE;
      end
    endcase

    // Flush overrides everything, including a start arriving in IDLE.
    if (flush_i) begin
      state_d  = DIV_IDLE;
      busy_d   = 1'b0;
      ready_d  = 1'b0;
      result_d = '0;
      rd_out_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= DIV_IDLE;
      op_q       <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      rd_q       <= '0;
      rem_q      <= '0;
      quot_q     <= '0;
      bmag_q     <= '0;
      count_q    <= '0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b0;
      result_q   <= '0;
      rd_out_q   <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      rd_q       <= rd_d;
      rem_q      <= rem_d;
      quot_q     <= quot_d;
      bmag_q     <= bmag_d;
      count_q    <= count_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
      result_q   <= result_d;
      rd_out_q   <= rd_out_d;
    end
  end

  assign busy_o    = busy_q;
  assign ready_o   = ready_q;
  assign result_o  = result_q;
  assign rd_addr_o = rd_out_q;

endmodule

// File: tb/tb_div.sv
// Self-checking bench for div: directed vector table, flush/reset/ignored-start sequences, random ops.
module tb_div;

  localparam logic [2:0] OP_DIV  = 3'b100;
  localparam logic [2:0] OP_DIVU = 3'b101;
  localparam logic [2:0] OP_REM  = 3'b110;
  localparam logic [2:0] OP_REMU = 3'b111;

`ifdef DIV_FAST_SPECIAL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic [2:0]  op_i = '0;
  logic [31:0] dividend_i = '0;
  logic [31:0] divisor_i = '0;
  logic [4:0]  rd_addr_i = '0;
  logic        flush_i = 1'b0;
  logic        busy_o;
  logic        ready_o;
  logic [31:0] result_o;
  logic [4:0]  rd_addr_o;

  int n_cmp = 0;
  int n_err = 0;

  div #(.XLEN(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (start_i),
    .op_i      (op_i),
    .dividend_i(dividend_i),
    .divisor_i (divisor_i),
    .rd_addr_i (rd_addr_i),
    .flush_i   (flush_i),
    .busy_o    (busy_o),
    .ready_o   (ready_o),
    .result_o  (result_o),
    .rd_addr_o (rd_addr_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string tag, input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s/%s: got %0h expected %0h", tag, name, act, exp);
    end
  endtask

  function automatic bit is_signed(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic bit is_special(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    return (b == 32'd0) || (is_signed(op) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // Architectural RV32M semantics from plain integer arithmetic.
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa;
    int sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return (op == OP_DIV || op == OP_DIVU) ? 32'hFFFF_FFFF : a;
    if (is_signed(op) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return (op == OP_DIV) ? 32'h8000_0000 : 32'd0;
    case (op)
      OP_DIV:  return sa / sb;
      OP_REM:  return sa % sb;
      OP_DIVU: return a / b;
      default: return a % b;
    endcase
  endfunction

  // Call just after a negedge: that cycle is cycle 0. Returns at a negedge inside the next op's cycle 0.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int flush_cyc, input int rst_cyc, input bit spur);
    logic [31:0] exp;
    int          lat;
    int          stop;
    bit          abort;
    int          ready_cnt;
    int          ready_cyc;
    logic [31:0] got_res;
    logic [4:0]  got_rd;
    int          busy_bad;
    logic [36:0] post;
    bit          exp_busy;
    exp       = model(op, a, b);
    lat       = (FAST && is_special(op, a, b)) ? 2 : 34;
    abort     = (flush_cyc > 0) || (rst_cyc > 0);
    stop      = (flush_cyc > 0) ? flush_cyc + 1 : (rst_cyc > 0) ? rst_cyc : lat + 1;
    ready_cnt = 0;
    ready_cyc = -1;
    got_res   = '0;
    got_rd    = '0;
    busy_bad  = 0;
    post      = '1;
    start_i    = 1'b1;
    op_i       = op;
    dividend_i = a;
    divisor_i  = b;
    rd_addr_i  = rd;
    for (int cyc = 1; cyc <= stop; cyc++) begin
      @(negedge clk);
      if (ready_o) begin
        ready_cnt++;
        ready_cyc = cyc;
        got_res   = result_o;
        got_rd    = rd_addr_o;
      end
      exp_busy = (cyc < lat) && !(flush_cyc > 0 && cyc > flush_cyc);
      if (busy_o !== exp_busy) busy_bad++;
      if (!abort && cyc == lat + 1) post = {result_o, rd_addr_o};
      if (cyc == 1) start_i = 1'b0;
      if (spur && cyc == 5) begin
        start_i    = 1'b1;
        op_i       = OP_DIVU;
        dividend_i = ~a;
        divisor_i  = 32'd3;
        rd_addr_i  = ~rd;
      end
      if (spur && cyc == 21) start_i = 1'b0;
      if (flush_cyc > 0 && cyc == flush_cyc) flush_i = 1'b1;
      if (flush_cyc > 0 && cyc == flush_cyc + 1) flush_i = 1'b0;
      if (rst_cyc > 0 && cyc == rst_cyc) begin
        rst_n = 1'b0;
        #1;
        chk(tag, "outputs_in_reset", {busy_o, ready_o, rd_addr_o, result_o}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
    chk(tag, "busy_profile_errors", busy_bad, 0);
    if (abort) begin
      chk(tag, "ready_count", ready_cnt, 0);
    end else begin
      chk(tag, "ready_count", ready_cnt, 1);
      chk(tag, "ready_cycle", ready_cyc, lat);
      chk(tag, "result", got_res, exp);
      chk(tag, "rd_addr", got_rd, rd);
      chk(tag, "post_ready_zero", post, 0);
    end
  endtask

  initial begin
    int seen;
    vecs.push_back('{OP_DIVU, 32'd100,        32'd7,          32'd14});
    vecs.push_back('{OP_REMU, 32'd100,        32'd7,          32'd2});
    vecs.push_back('{OP_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD});
    vecs.push_back('{OP_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF});
    vecs.push_back('{OP_DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD});
    vecs.push_back('{OP_REM,  32'd7,          32'hFFFF_FFFE,  32'd1});
    vecs.push_back('{OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000});
    vecs.push_back('{OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0});
    vecs.push_back('{OP_DIVU, 32'd5,          32'd0,          32'hFFFF_FFFF});
    vecs.push_back('{OP_REMU, 32'd5,          32'd0,          32'd5});
    vecs.push_back('{OP_DIV,  32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF});
    vecs.push_back('{OP_REM,  32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB});
    vecs.push_back('{OP_DIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF});
    vecs.push_back('{OP_REMU, 32'hFFFF_FFFF,  32'h10,         32'hF});
    vecs.push_back('{OP_DIV,  32'd0,          32'd5,          32'd0});
    vecs.push_back('{OP_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0});

    #1;
    chk("reset", "outputs_async", {busy_o, ready_o, rd_addr_o, result_o}, 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset", "outputs_after_release", {busy_o, ready_o, rd_addr_o, result_o}, 64'd0);

    start_i    = 1'b1;
    flush_i    = 1'b1;
    op_i       = OP_DIVU;
    dividend_i = 32'd9;
    divisor_i  = 32'd3;
    rd_addr_i  = 5'd4;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start_i = 1'b0;
      flush_i = 1'b0;
      if (busy_o || ready_o) seen++;
    end
    chk("flush_vs_start", "busy_or_ready_cycles", seen, 0);

    foreach (vecs[i]) begin
      logic [31:0] e;
      e = model(vecs[i].op, vecs[i].a, vecs[i].b);
      chk($sformatf("vec%0d", i), "table_vs_model", e, vecs[i].exp);
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, 5'(i + 1), 0, 0, 1'b0);
    end

    run_op("spurious_start", OP_DIVU, 32'd100, 32'd7, 5'd17, 0, 0, 1'b1);
    run_op("flushed_op", OP_DIV, 32'd1234, 32'd11, 5'd9, 10, 0, 1'b0);
    run_op("after_flush", OP_REMU, 32'd1234, 32'd11, 5'd10, 0, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      op = 3'(4 + $urandom_range(0, 3));
      a  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = $urandom_range(1, 20);
        3:       b = 32'(-$urandom_range(1, 20));
        default: b = $urandom;
      endcase
      run_op($sformatf("rand%0d", i), op, a, b, 5'($urandom), 0, 0, 1'b0);
    end

    run_op("reset_mid_op", OP_DIV, 32'hDEAD_BEEF, 32'd77, 5'd21, 0, 20, 1'b0);
    run_op("after_reset", OP_REM, 32'hDEAD_BEEF, 32'd77, 5'd22, 0, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/div.md
# div

- Multi-cycle RV32M divide unit for DIV, DIVU, REM and REMU.
- Sits directly downstream of the execute stage:
  - ex issues operands and a start strobe, then raises its hold request to ctrl while busy_o is high.
  - ex consumes result_o and rd_addr_o on the ready_o pulse and forwards them to the register-file write port.
- Implemented as a radix-2 restoring divider, one quotient bit per cycle, with a one-cycle special-case pre-check.

## Interface

Parameters:
- XLEN, default 32: operand and result width; only 32 is supported.

Ports:
- Clocking: single clock `clk`; reset `rst_n` is asynchronous and active-low.
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start_i  in  1  start strobe; sampled only in IDLE.
- op_i  in  3  func3 code: 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- dividend_i  in  32  rs1 value.
- divisor_i  in  32  rs2 value.
- rd_addr_i  in  5  destination register, captured at start.
- flush_i  in  1  jump/flush from ctrl; aborts any operation in progress.
- busy_o  out  1  divide in progress; drives ex hold_flag.
- ready_o  out  1  one-cycle result-valid pulse.
- result_o  out  32  quotient or remainder; valid only while ready_o is high.
- rd_addr_o  out  5  captured rd_addr_i; valid while ready_o is high.

## Operation

States:
- IDLE → START on start_i && !flush_i. Operands, op and rd_addr are captured.
- START:
  - Special case (macro on) → END.
  - Otherwise → CALC with count = 0.
  - Magnitudes are taken here: |a| and |b| for DIV/REM, raw values for DIVU/REMU.
- CALC, 32 iterations:
  - Shift {rem, quot} left by 1.
  - Trial subtract rem[32:0] − {1'b0, |b|}.
  - Non-negative result: keep it and set the quotient LSB.
  - count == 31 → END.
- END:
  - Apply sign fixup.
  - Drive result_o, rd_addr_o and ready_o for one cycle.
  - → IDLE.

Sign rules (signed ops):
- Quotient is negated when sign(a) ≠ sign(b) and b ≠ 0.
- Remainder takes the sign of a.
- Negation is two's complement, 32-bit wrap.

Required results:
- b = 0: quotient = 0xFFFFFFFF; remainder = dividend.
- DIV 0x80000000 / 0xFFFFFFFF: quotient = 0x80000000, remainder = 0.

Boundary behaviour:
- start_i while not IDLE: ignored, no queuing.
- flush_i in any state: → IDLE on the next edge. No ready_o pulse; busy_o low from that edge on.
- flush_i and start_i together in IDLE: flush wins, start is dropped.
- rst_n low at any time: immediately IDLE, all outputs 0.
- Back-to-back: a new start_i may be sampled in the IDLE cycle right after END.

## Timing

- Cycle 0 is the cycle in which start_i is sampled high in IDLE.
- Normal path:
  - busy_o high in cycles 1–33.
  - ready_o high in cycle 34 only.
  - busy_o is low during the ready cycle.
- Special path (macro on): busy_o high in cycle 1; ready_o high in cycle 2.
- All outputs are registered. Reset values: busy_o 0, ready_o 0, result_o 0, rd_addr_o 0, state IDLE.
- result_o and rd_addr_o return to 0 in the cycle after ready_o.

## Configuration

DIV_FAST_SPECIAL_EN:
- Defined: divide-by-zero and signed overflow are detected in START. The architected result is loaded directly and the unit goes to END, giving a 2-cycle latency.
- Undefined: those cases run all 32 iterations.
  - Unsigned b = 0 produces the correct values through the datapath.
  - END suppresses quotient negation when b = 0, so the result is still correct.
  - Latency is a uniform 34 cycles.
- Results must be identical either way; only the latency differs.

## Structure

- Shared defines file holds:
  - the func3 codes INST_DIV, INST_DIVU, INST_REM, INST_REMU (alongside the existing INST_TYPE_R_M codes);
  - the state encodings DIV_IDLE, DIV_START, DIV_CALC, DIV_END.
- No sub-module is needed: the iteration step, magnitude and fixup logic are inline in div.

## Test plan

1. DIVU 100 / 7 → result_o 14, ready_o in cycle 34; REMU → 2.
2. DIV −7 / 2 → 0xFFFFFFFD; REM −7 / 2 → 0xFFFFFFFF; DIV 7 / −2 → 0xFFFFFFFD.
3. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM → 0.
4. b = 0 cases:
   - DIVU 5 / 0 → 0xFFFFFFFF; REMU 5 / 0 → 5; DIV −5 / 0 → 0xFFFFFFFF.
   - ready_o in cycle 2 with DIV_FAST_SPECIAL_EN, cycle 34 without.
5. flush_i in cycle 10:
   - No ready_o; busy_o low from cycle 11.
   - A start_i in cycle 11 completes normally with ready_o in cycle 45.
6. Reset and ignored start:
   - start_i re-asserted in cycles 5–20 is ignored, and ready_o still pulses only once, in cycle 34.
   - rst_n low in cycle 20 of a later op → all outputs 0 at once, no ready_o.
